// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM feeding decode.
// Optional misaligned-target check enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCsrc,
    input  logic [31:0] ImmOp,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [2:0]  IDLE  = 3'd0;
    localparam logic [2:0]  REQ   = 3'd1;
    localparam logic [2:0]  WAIT  = 3'd2;
    localparam logic [2:0]  HOLD  = 3'd3;
    localparam logic [2:0]  FAULT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] next_pc;
    logic        misaligned;

    // Wraps modulo 2^32 by construction of the 32-bit adders.
    assign next_pc = PCsrc ? (pc_q + ImmOp) : (pc_q + 32'd4);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned  = |next_pc[1:0];
    assign fetch_fault = (state_q == FAULT);
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                addr_d  = RESET_PC;
                state_d = REQ;
            end
            REQ: begin
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    pc_d    = addr_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Branch inputs only matter on the cycle decode accepts the instruction.
                if (instr_ready) begin
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        addr_d  = next_pc;
                        state_d = REQ;
                    end
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            instr_q <= NOP;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = addr_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign instr_valid = (state_q == HOLD);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port PCsrc  input  1  branch-taken flag for the instruction currently presented, from the control unit.
REQ-005 Port ImmOp  input  32  sign-extended branch offset for the presented instruction.
REQ-006 Port imem_req  output  1  instruction-memory request.
REQ-007 Port imem_addr  output  32  request address.
REQ-008 Port imem_gnt  input  1  memory accepts request this cycle.
REQ-009 Port imem_rvalid  input  1  read data valid.
REQ-010 Port imem_rdata  input  32  read data.
REQ-011 Port Instr  output  32  instruction presented to decode.
REQ-012 Port PC  output  32  address of Instr.
REQ-013 Port instr_valid  output  1  Instr/PC valid.
REQ-014 Port instr_ready  input  1  decode consumes Instr this cycle.
REQ-015 Port fetch_fault  output  1  sticky misaligned-target fault.

Function
REQ-016 FSM states IDLE, REQ, WAIT, HOLD, FAULT; exactly one outstanding request.
REQ-017 IDLE: one cycle after reset release, then REQ with fetch address = RESET_PC.
REQ-018 REQ: imem_req=1, imem_addr=fetch address; address held stable until imem_gnt; on imem_gnt go to WAIT next cycle.
REQ-019 WAIT: imem_req=0; on imem_rvalid latch imem_rdata into Instr, fetch address into PC, go to HOLD.
REQ-020 imem_rvalid outside WAIT is ignored; no state or output change.
REQ-021 HOLD: instr_valid=1; Instr and PC held stable while instr_ready=0.
REQ-022 HOLD with instr_ready=1: next address = PCsrc ? PC+ImmOp : PC+4; go to REQ next cycle; instr_valid=0 in that next cycle.
REQ-023 PCsrc and ImmOp sampled only in the HOLD cycle where instr_ready=1; ignored otherwise.
REQ-024 All address arithmetic is 32-bit modulo; PC=32'hFFFF_FFFC with PCsrc=0 wraps to 32'h0000_0000.
REQ-025 Minimum latency: imem_gnt in cycle N, imem_rvalid in N+1 -> instr_valid=1 in N+2.
REQ-026 instr_valid=0 in every state except HOLD; imem_req=1 only in REQ.

Reset
REQ-027 rst_n=0 forces IDLE immediately, regardless of state or outstanding request.
REQ-028 Reset values: imem_req=0, imem_addr=RESET_PC, Instr=32'h0000_0013 (NOP), PC=RESET_PC, instr_valid=0, fetch_fault=0.
REQ-029 A request outstanding at reset is abandoned; its late imem_rvalid is ignored per REQ-020.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN.
REQ-031 Defined: in HOLD with instr_ready=1, a next address with bits[1:0]!=0 enters FAULT; FAULT holds imem_req=0, instr_valid=0, fetch_fault=1 until reset.
REQ-032 Undefined: no check, FAULT unreachable, fetch_fault tied 0, misaligned address issued as computed.

Verification
REQ-033 Reset release, RESET_PC=0, gnt same cycle, rvalid next with rdata=32'h00500093 -> instr_valid=1 two cycles after gnt, Instr=32'h00500093, PC=0.
REQ-034 HOLD, instr_ready=0 for 5 cycles -> Instr/PC stable, imem_req=0; then ready=1, PCsrc=0 -> imem_addr=4.
REQ-035 PC=32'h10, PCsrc=1, ImmOp=32'hFFFF_FFF8, ready=1 -> next imem_addr=32'h8; PCsrc=1 with ready=0 -> no effect.
REQ-036 PC=32'hFFFF_FFFC, PCsrc=0, ready=1 -> imem_addr=0; gnt held low 3 cycles -> imem_req and imem_addr stable.
REQ-037 rst_n pulsed low in WAIT, rvalid arrives after release -> ignored, fetch restarts at RESET_PC.
REQ-038 With FETCH_ALIGN_CHECK_EN, PC=0, PCsrc=1, ImmOp=2 -> fetch_fault=1, imem_req=0 until reset; without it -> imem_addr=2, fetch_fault=0.
